// File: rtl/ed_sweep_gen.sv
// -----------------------------------------------------------------------------
// ed_sweep_gen
//
// Purpose:
//   Feeds the two-minimum finder of the tree-search detector. For a single
//   parent node it sweeps every child QAM constellation point and streams one
//   (accumulated ED, child index) pair per clock:
//       ED = parent_ped + |y - r*s|^2
//   The stream is framed by enable_out. The falling edge of enable_out after
//   the last pair is what clears the downstream running minima.
//
// Ports:
//   clk         in   1    clock, rising edge
//   rst         in   1    synchronous active-high reset
//   start       in   1    one-cycle sweep request, honoured only while idle
//   y_re        in   DW   signed received real component
//   y_im        in   DW   signed received imaginary component
//   r_gain      in   RW   unsigned diagonal channel gain
//   parent_ped  in   31   unsigned parent partial ED
//   enable_out  out  1    high exactly while ed_out/node_out are valid
//   ed_out      out  32   accumulated ED, saturated to 0x7FFF_FFFF
//   node_out    out  32   child index, zero-extended
//   busy        out  1    sweep in progress
//   done        out  1    one-cycle pulse when the sweep has drained
//
// Latency from issuing a child index to its pair on the outputs is 2 cycles.
// -----------------------------------------------------------------------------
module ed_sweep_gen #(
    parameter int unsigned DW  = 16,
    parameter int unsigned RW  = 8,
    parameter int unsigned BPD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] y_re,
    input  logic signed [DW-1:0] y_im,
    input  logic        [RW-1:0] r_gain,
    input  logic        [30:0]   parent_ped,
    output logic                 enable_out,
    output logic        [31:0]   ed_out,
    output logic        [31:0]   node_out,
    output logic                 busy,
    output logic                 done
);

    // Widths
    localparam int unsigned IW    = 2 * BPD;          // child index width
    localparam int unsigned NODES = 1 << IW;          // children per parent
    localparam int unsigned SW    = BPD + 2;          // signed symbol coordinate
    localparam int unsigned DFW   = DW + RW + 3;      // stage-1 difference width
    localparam int          MAXC  = (1 << BPD) - 1;   // largest |coordinate|

    // FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Control state
    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;

    // Operands latched at start; stable for the whole sweep
    logic signed [DW-1:0] r_y_re;
    logic signed [DW-1:0] r_y_im;
    logic        [RW-1:0] r_r;
    logic        [30:0]   r_ped;

    // Stage 1
    logic                  r_v1;
    logic signed [DFW-1:0] r_dre1;
    logic signed [DFW-1:0] r_dim1;
    logic        [IW-1:0]  r_node1;

    // Next-state / control decode
    logic [1:0]    w_state_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic          w_issue;
    logic          w_latch;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    // Datapath wires
    logic signed [SW-1:0]  w_s_re;
    logic signed [SW-1:0]  w_s_im;
    logic signed [DFW-1:0] w_y_re_ext;
    logic signed [DFW-1:0] w_y_im_ext;
    logic signed [DFW-1:0] w_r_ext;
    logic signed [DFW-1:0] w_s_re_ext;
    logic signed [DFW-1:0] w_s_im_ext;
    logic signed [DFW-1:0] w_d_re;
    logic signed [DFW-1:0] w_d_im;
    logic signed [63:0]    w_dre64;
    logic signed [63:0]    w_dim64;
    logic signed [63:0]    w_sq_re;
    logic signed [63:0]    w_sq_im;
    logic        [63:0]    w_sum;
    logic        [31:0]    w_ed_sat;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_issue     = 1'b0;
        w_latch     = 1'b0;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SWEEP;
                end
            end
            S_SWEEP: begin
                w_issue   = 1'b1;
                w_idx_nxt = r_idx + IW'(1);
                if (r_idx == IW'(NODES - 1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Stage 1 empty means the last pair now sits in stage 2 and
                // leaves at this edge; enable_out drops together with done.
                if (!r_v1) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sweep index, operand latch and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_y_re <= '0;
            r_y_im <= '0;
            r_r    <= '0;
            r_ped  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            r_idx <= w_idx_nxt;
            busy  <= w_busy_nxt;
            done  <= w_done_nxt;
            if (w_latch) begin
                r_y_re <= y_re;
                r_y_im <= y_im;
                r_r    <= r_gain;
                r_ped  <= parent_ped;
            end
        end
    end

    // Symbol mapping: low BPD index bits select the real coordinate
    always_comb begin
        w_s_re = SW'(2 * int'(r_idx[BPD-1:0]) - MAXC);
        w_s_im = SW'(2 * int'(r_idx[IW-1:BPD]) - MAXC);
    end

    // Stage-1 differences at full width; sign-extend everything first
    always_comb begin
        w_y_re_ext = DFW'(r_y_re);
        w_y_im_ext = DFW'(r_y_im);
        w_r_ext    = DFW'({1'b0, r_r});
        w_s_re_ext = DFW'(w_s_re);
        w_s_im_ext = DFW'(w_s_im);
        w_d_re     = w_y_re_ext - (w_r_ext * w_s_re_ext);
        w_d_im     = w_y_im_ext - (w_r_ext * w_s_im_ext);
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_dre1  <= '0;
            r_dim1  <= '0;
            r_node1 <= '0;
        end else begin
            r_v1 <= w_issue;
            if (w_issue) begin
                r_dre1  <= w_d_re;
                r_dim1  <= w_d_im;
                r_node1 <= r_idx;
            end
        end
    end

    // Stage-2 squared distance in 64 bits, saturated into 31 bits
    always_comb begin
        w_dre64  = 64'(r_dre1);
        w_dim64  = 64'(r_dim1);
        w_sq_re  = w_dre64 * w_dre64;
        w_sq_im  = w_dim64 * w_dim64;
        w_sum    = 64'(r_ped) + 64'(w_sq_re) + 64'(w_sq_im);
        w_ed_sat = (w_sum > 64'h0000_0000_7FFF_FFFF) ? 32'h7FFF_FFFF
                                                      : {1'b0, w_sum[30:0]};
    end

    // Stage 2 register drives the output pair; data holds when not valid
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_out <= 1'b0;
            ed_out     <= '0;
            node_out   <= '0;
        end else begin
            enable_out <= r_v1;
            if (r_v1) begin
                ed_out   <= w_ed_sat;
                node_out <= 32'(r_node1);
            end
        end
    end

endmodule

// File: tb/tb_ed_sweep_gen.sv
// -----------------------------------------------------------------------------
// tb_ed_sweep_gen
//
// Purpose: self-checking bench for ed_sweep_gen. Expected (ED, node) pairs are
// pushed when a sweep is started and popped as enable_out presents them;
// frame timing, handshakes and named spot values are checked directly.
// -----------------------------------------------------------------------------
module tb_ed_sweep_gen;

    localparam int NODES = 16;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [15:0] y_re;
    logic signed [15:0] y_im;
    logic        [7:0]  r_gain;
    logic        [30:0] parent_ped;
    logic               enable_out;
    logic        [31:0] ed_out;
    logic        [31:0] node_out;
    logic               busy;
    logic               done;

    ed_sweep_gen #(.DW(16), .RW(8), .BPD(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .y_re       (y_re),
        .y_im       (y_im),
        .r_gain     (r_gain),
        .parent_ped (parent_ped),
        .enable_out (enable_out),
        .ed_out     (ed_out),
        .node_out   (node_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ed;
        logic [31:0] node;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    // Observations gathered by the monitor for the current frame
    logic [31:0] obs_ed [NODES];
    logic [31:0] obs_min_ed;
    logic [31:0] obs_min_node;
    int          low_run = 0;
    bit          prev_en = 1'b0;
    bit          seen_frame = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Reference ED for one child
    function automatic logic [31:0] model_ed(input int yr, input int yi, input int r,
                                             input longint ped, input int k);
        longint sre, sim, dre, dim, sum;
        sre = longint'(2 * (k % 4) - 3);
        sim = longint'(2 * (k / 4) - 3);
        dre = longint'(yr) - longint'(r) * sre;
        dim = longint'(yi) - longint'(r) * sim;
        sum = ped + dre * dre + dim * dim;
        return (sum > 64'sh7FFF_FFFF) ? 32'h7FFF_FFFF : 32'(sum);
    endfunction

    task automatic push_sweep(input int yr, input int yi, input int r, input longint ped);
        exp_t e;
        for (int k = 0; k < NODES; k++) begin
            e.ed   = model_ed(yr, yi, r, ped, k);
            e.node = 32'(k);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard monitor: compares each presented pair with the queue head
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            low_run    = 0;
            prev_en    = 1'b0;
            seen_frame = 1'b0;
        end else begin
            if (enable_out) begin
                if (!prev_en) begin
                    if (seen_frame) check("gap_low_cycles_ge2", 64'(low_run >= 2), 64'(1));
                    seen_frame   = 1'b1;
                    obs_min_ed   = 32'hFFFF_FFFF;
                    obs_min_node = 32'hFFFF_FFFF;
                end
                check("sb_not_empty", 64'(exp_q.size() > 0), 64'(1));
                check("ed_bit31", 64'(ed_out[31]), 64'(0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_node", 64'(node_out), 64'(e.node));
                    check("sb_ed", 64'(ed_out), 64'(e.ed));
                end
                obs_ed[node_out[3:0]] = ed_out;
                if (ed_out < obs_min_ed) begin
                    obs_min_ed   = ed_out;
                    obs_min_node = node_out;
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_en = enable_out;
        end
    end

    // Start a sweep at the current negedge and check the frame cycle by cycle.
    // Returns at the negedge of the done cycle (earliest point for a new start).
    task automatic run_sweep(input int yr, input int yi, input int r,
                             input longint ped, input int inj_at);
        y_re       = 16'(yr);
        y_im       = 16'(yi);
        r_gain     = 8'(r);
        parent_ped = 31'(ped);
        start      = 1'b1;
        push_sweep(yr, yi, r, ped);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        check("en_after_start", 64'(enable_out), 64'(0));
        check("done_after_start", 64'(done), 64'(0));
        for (int c = 1; c <= NODES + 2; c++) begin
            start = (c == inj_at);
            if (c == inj_at) begin
                y_re       = 16'sd100;
                y_im       = -16'sd200;
                r_gain     = 8'd5;
                parent_ped = 31'd7;
            end
            @(negedge clk);
            check($sformatf("en_c%0d", c), 64'(enable_out), 64'(c >= 2 && c <= NODES + 1));
            check($sformatf("done_c%0d", c), 64'(done), 64'(c == NODES + 2));
            check($sformatf("busy_c%0d", c), 64'(busy), 64'(c <= NODES + 1));
        end
        start = 1'b0;
        check("sb_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        y_re       = '0;
        y_im       = '0;
        r_gain     = '0;
        parent_ped = '0;
        repeat (3) @(negedge clk);
        check("rst_en", 64'(enable_out), 64'(0));
        check("rst_ed", 64'(ed_out), 64'(0));
        check("rst_node", 64'(node_out), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero input
        run_sweep(0, 0, 1, 0, 0);
        check("zero_n0", 64'(obs_ed[0]), 64'(18));
        check("zero_n5", 64'(obs_ed[5]), 64'(2));
        check("zero_n6", 64'(obs_ed[6]), 64'(2));
        check("zero_n9", 64'(obs_ed[9]), 64'(2));
        check("zero_n10", 64'(obs_ed[10]), 64'(2));
        check("zero_n15", 64'(obs_ed[15]), 64'(18));
        repeat (3) @(negedge clk);

        // Exact hit, with a spurious start mid-sweep
        run_sweep(3, -1, 1, 10, 6);
        check("hit_n7", 64'(obs_ed[7]), 64'(10));
        check("hit_n0", 64'(obs_ed[0]), 64'(50));
        check("hit_min_node", 64'(obs_min_node), 64'(7));
        repeat (3) @(negedge clk);

        // Gain scaling, then back-to-back saturation sweep at earliest edge
        run_sweep(6, 6, 2, 0, 0);
        check("gain_n15", 64'(obs_ed[15]), 64'(0));
        check("gain_n10", 64'(obs_ed[10]), 64'(32));
        check("gain_n0", 64'(obs_ed[0]), 64'(288));
        run_sweep(32767, 32767, 0, 1000000, 0);
        for (int k = 0; k < NODES; k++)
            check($sformatf("sat_n%0d", k), 64'(obs_ed[k]), 64'h7FFF_FFFF);
        repeat (3) @(negedge clk);

        // Reset at pair 5
        y_re       = 16'sd3;
        y_im       = -16'sd1;
        r_gain     = 8'd1;
        parent_ped = 31'd10;
        start      = 1'b1;
        push_sweep(3, -1, 1, 10);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pair5_visible", 64'(enable_out), 64'(1));
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_en", 64'(enable_out), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_pending", 64'(exp_q.size()), 64'(10));
        exp_q.delete();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("postrst_no_done", 64'(done), 64'(0));
            check("postrst_en_low", 64'(enable_out), 64'(0));
        end

        // Full sweep after the abandoned one
        run_sweep(6, 6, 2, 0, 0);
        check("postrst_n15", 64'(obs_ed[15]), 64'(0));
        check("postrst_n0", 64'(obs_ed[0]), 64'(288));
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
